// File: rtl/ram_1r1w_rr_arbiter.sv
// Shares one 1R1W synchronous RAM among clients_p requesters with independent round-robin
// write and read arbitration; zero-fills the RAM after reset. Optional macro: RAW_BYPASS_EN.
`timescale 1ns/1ps
module ram_1r1w_rr_arbiter #(
  parameter int width_p   = 8,
  parameter int depth_p   = 512,
  parameter int clients_p = 2,
  localparam int aw_lp    = $clog2(depth_p),
  localparam int cw_lp    = $clog2(clients_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [clients_p-1:0]         wr_valid_i,
  input  logic [clients_p*aw_lp-1:0]   wr_addr_i,
  input  logic [clients_p*width_p-1:0] wr_data_i,
  output logic [clients_p-1:0]         wr_ready_o,
  input  logic [clients_p-1:0]         rd_valid_i,
  input  logic [clients_p*aw_lp-1:0]   rd_addr_i,
  output logic [clients_p-1:0]         rd_ready_o,
  output logic [clients_p-1:0]         rd_data_valid_o,
  output logic [width_p-1:0]           rd_data_o,
  output logic                         ram_wr_valid_o,
  output logic [aw_lp-1:0]             ram_wr_addr_o,
  output logic [width_p-1:0]           ram_wr_data_o,
  output logic                         ram_rd_valid_o,
  output logic [aw_lp-1:0]             ram_rd_addr_o,
  input  logic [width_p-1:0]           ram_rd_data_i
);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e               state_q, state_d;
  logic [aw_lp-1:0]     clearCnt_q, clearCnt_d;
  logic [cw_lp-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [clients_p-1:0] rdDataValid_q, rdDataValid_d;
  logic [cw_lp:0]       wrPick, rdPick;
  logic                 wrReq, rdReq;
  logic [cw_lp-1:0]     wrIdx, rdIdx;

  // Returns {found, index}; scanning offsets high-to-low lets the lowest offset from ptr win.
  function automatic logic [cw_lp:0] rrPick(input logic [clients_p-1:0] req,
                                            input logic [cw_lp-1:0] ptr);
    logic [cw_lp:0] pick;
    int idx;
    pick = '0;
    for (int i = clients_p - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= clients_p) idx = idx - clients_p;
      if (req[idx[cw_lp-1:0]]) pick = {1'b1, idx[cw_lp-1:0]};
    end
    return pick;
  endfunction

  function automatic logic [cw_lp-1:0] nextPtr(input logic [cw_lp-1:0] k);
    if (int'(k) == clients_p - 1) return '0;
    return k + cw_lp'(1);
  endfunction

  function automatic logic [clients_p-1:0] oneHot(input logic [cw_lp-1:0] k);
    logic [clients_p-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  assign wrPick = rrPick(wr_valid_i, wrPtr_q);
  assign rdPick = rrPick(rd_valid_i, rdPtr_q);
  assign wrReq  = wrPick[cw_lp];
  assign rdReq  = rdPick[cw_lp];
  assign wrIdx  = wrPick[cw_lp-1:0];
  assign rdIdx  = rdPick[cw_lp-1:0];

  always_comb begin
    state_d        = state_q;
    clearCnt_d     = clearCnt_q;
    wrPtr_d        = wrPtr_q;
    rdPtr_d        = rdPtr_q;
    rdDataValid_d  = '0;
    wr_ready_o     = '0;
    rd_ready_o     = '0;
    ram_wr_valid_o = 1'b0;
    ram_wr_addr_o  = '0;
    ram_wr_data_o  = '0;
    ram_rd_valid_o = 1'b0;
    ram_rd_addr_o  = '0;
    case (state_q)
      CLEAR: begin
        ram_wr_valid_o = 1'b1;
        ram_wr_addr_o  = clearCnt_q;
        clearCnt_d     = clearCnt_q + aw_lp'(1);
        if (clearCnt_q == aw_lp'(depth_p - 1)) begin
          state_d    = RUN;
          clearCnt_d = '0;
        end
      end
      default: begin
        if (wrReq) begin
          wr_ready_o     = oneHot(wrIdx);
          ram_wr_valid_o = 1'b1;
          ram_wr_addr_o  = wr_addr_i[wrIdx*aw_lp +: aw_lp];
          ram_wr_data_o  = wr_data_i[wrIdx*width_p +: width_p];
          wrPtr_d        = nextPtr(wrIdx);
        end
        if (rdReq) begin
          rd_ready_o     = oneHot(rdIdx);
          ram_rd_valid_o = 1'b1;
          ram_rd_addr_o  = rd_addr_i[rdIdx*aw_lp +: aw_lp];
          rdDataValid_d  = oneHot(rdIdx);
          rdPtr_d        = nextPtr(rdIdx);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= CLEAR;
      clearCnt_q    <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      rdDataValid_q <= '0;
    end else begin
      state_q       <= state_d;
      clearCnt_q    <= clearCnt_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      rdDataValid_q <= rdDataValid_d;
    end
  end

  assign rd_data_valid_o = rdDataValid_q;

`ifdef RAW_BYPASS_EN
  // A read colliding with a same-cycle write would see stale RAM data; forward the write instead.
  logic               bypass_q, bypass_d;
  logic [width_p-1:0] bypassData_q, bypassData_d;

  always_comb begin
    bypass_d     = (state_q == RUN) && wrReq && rdReq && (ram_wr_addr_o == ram_rd_addr_o);
    bypassData_d = ram_wr_data_o;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) bypass_q <= 1'b0;
    else         bypass_q <= bypass_d;
    bypassData_q <= bypassData_d;
  end

  assign rd_data_o = bypass_q ? bypassData_q : ram_rd_data_i;
`else
  assign rd_data_o = ram_rd_data_i;
`endif

endmodule

// File: tb/tb_ram_1r1w_rr_arbiter.sv
// Scoreboard bench for ram_1r1w_rr_arbiter with a behavioural read-old 1R1W RAM attached.
`timescale 1ns/1ps
module tb_ram_1r1w_rr_arbiter;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int C  = 2;
  localparam int AW = 3;

`ifdef RAW_BYPASS_EN
  localparam logic [7:0] RawExp = 8'h22;
`else
  localparam logic [7:0] RawExp = 8'h11;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [C-1:0]  wrValid, wrReady, rdValid, rdReady, rdDataValid;
  logic [C*AW-1:0] wrAddr, rdAddr;
  logic [C*W-1:0]  wrData;
  logic [W-1:0]  rdData, ramWrData;
  logic [W-1:0]  ramRdData = '0;
  logic          ramWrValid, ramRdValid;
  logic [AW-1:0] ramWrAddr, ramRdAddr;
  logic [W-1:0]  mem [D];
  logic          memPrimed = 1'b0;
  logic          monitorOn = 1'b0;

  typedef struct packed {
    logic [C-1:0] oh;
    logic [W-1:0] data;
  } resp_t;

  resp_t sbQ[$];
  int    checks = 0;
  int    errors = 0;
  int    clearLen;

  ram_1r1w_rr_arbiter #(.width_p(W), .depth_p(D), .clients_p(C)) dut (
    .clk_i(clk), .reset_i(reset),
    .wr_valid_i(wrValid), .wr_addr_i(wrAddr), .wr_data_i(wrData), .wr_ready_o(wrReady),
    .rd_valid_i(rdValid), .rd_addr_i(rdAddr), .rd_ready_o(rdReady),
    .rd_data_valid_o(rdDataValid), .rd_data_o(rdData),
    .ram_wr_valid_o(ramWrValid), .ram_wr_addr_o(ramWrAddr), .ram_wr_data_o(ramWrData),
    .ram_rd_valid_o(ramRdValid), .ram_rd_addr_o(ramRdAddr), .ram_rd_data_i(ramRdData)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: garbage-filled at start so the zero-fill is observable; reads return old data.
  always @(posedge clk) begin
    if (!memPrimed) begin
      for (int i = 0; i < D; i++) mem[i] <= 8'hEE;
      memPrimed <= 1'b1;
    end else begin
      if (ramRdValid === 1'b1) ramRdData <= mem[ramRdAddr];
      if (ramWrValid === 1'b1) mem[ramWrAddr] <= ramWrData;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] wv, input logic [5:0] wa, input logic [15:0] wd,
                               input logic [1:0] rv, input logic [5:0] ra);
    wrValid = wv;
    wrAddr  = wa;
    wrData  = wd;
    rdValid = rv;
    rdAddr  = ra;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectRead(input logic [1:0] oh, input logic [7:0] data);
    checkOutput("rdReady", rdReady, oh);
    sbQ.push_back('{oh: oh, data: data});
  endtask

  // Monitor: pops an expected response whenever the DUT presents one.
  always @(negedge clk) begin
    resp_t exp;
    #2;
    if (monitorOn && rdDataValid !== 2'b00) begin
      if (sbQ.size() == 0) begin
        checkOutput("rdRespUnexpected", rdDataValid, 0);
      end else begin
        exp = sbQ.pop_front();
        checkOutput("rdRespValid", rdDataValid, exp.oh);
        checkOutput("rdRespData", rdData, exp.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(2'b00, '0, '0, 2'b00, '0);
    nextCycle();
    monitorOn = 1'b1;
    nextCycle();
    reset = 1'b0;

    // Zero-fill: requests held high must not be granted.
    applyStimulus(2'b11, {3'd2, 3'd1}, {8'h55, 8'h66}, 2'b11, {3'd2, 3'd1});
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      checkOutput("clearCycle", {ramWrValid, ramWrAddr, ramWrData, wrReady, rdReady, ramRdValid},
                  {1'b1, 3'(i), 8'h00, 2'b00, 2'b00, 1'b0});
      if (i == D - 1) applyStimulus(2'b00, '0, '0, 2'b00, '0);
      nextCycle();
    end
    applyStimulus(2'b00, '0, '0, 2'b01, {3'd0, 3'd5});
    @(negedge clk);
    checkOutput("clearDone", ramWrValid, 0);
    checkOutput("ramRdAddr", {ramRdValid, ramRdAddr}, {1'b1, 3'd5});
    expectRead(2'b01, 8'h00);
    nextCycle();

    // Single client write then read.
    applyStimulus(2'b01, {3'd0, 3'd3}, {8'h00, 8'hA5}, 2'b00, '0);
    @(negedge clk);
    checkOutput("wrSingle", {wrReady, ramWrValid, ramWrAddr, ramWrData}, {2'b01, 1'b1, 3'd3, 8'hA5});
    nextCycle();
    applyStimulus(2'b00, '0, '0, 2'b01, {3'd0, 3'd3});
    @(negedge clk);
    checkOutput("rdValidIdle", rdDataValid, 0);
    expectRead(2'b01, 8'hA5);
    nextCycle();
    applyStimulus(2'b10, {3'd4, 3'd0}, {8'h77, 8'h00}, 2'b00, '0);
    @(negedge clk);
    checkOutput("wrClient1", {wrReady, ramWrAddr, ramWrData}, {2'b10, 3'd4, 8'h77});
    nextCycle();

    // Write contention alternates starting at client 0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, {3'd2, 3'd1}, {8'hC3, 8'h3C}, 2'b00, '0);
      @(negedge clk);
      if (i % 2 == 0) checkOutput("wrRR", {wrReady, ramWrAddr, ramWrData}, {2'b01, 3'd1, 8'h3C});
      else            checkOutput("wrRR", {wrReady, ramWrAddr, ramWrData}, {2'b10, 3'd2, 8'hC3});
      nextCycle();
    end
    applyStimulus(2'b00, '0, '0, 2'b11, {3'd2, 3'd1});
    @(negedge clk);
    expectRead(2'b10, 8'hC3);
    nextCycle();
    @(negedge clk);
    expectRead(2'b01, 8'h3C);
    nextCycle();
    applyStimulus(2'b00, '0, '0, 2'b10, {3'd4, 3'd0});
    @(negedge clk);
    expectRead(2'b10, 8'h77);
    nextCycle();

    // Same-cycle read and write to address 7.
    applyStimulus(2'b10, {3'd7, 3'd0}, {8'h11, 8'h00}, 2'b00, '0);
    @(negedge clk);
    checkOutput("wrRawSetup", wrReady, 2'b10);
    nextCycle();
    applyStimulus(2'b01, {3'd0, 3'd7}, {8'h00, 8'h22}, 2'b10, {3'd7, 3'd0});
    @(negedge clk);
    checkOutput("wrRaw", wrReady, 2'b01);
    expectRead(2'b10, RawExp);
    nextCycle();
    applyStimulus(2'b00, '0, '0, 2'b10, {3'd7, 3'd0});
    @(negedge clk);
    expectRead(2'b10, 8'h22);
    nextCycle();
    applyStimulus(2'b00, '0, '0, 2'b00, '0);
    @(negedge clk);
    #3;
    checkOutput("sbDrainedA", sbQ.size(), 0);
    nextCycle();

    // Reset while a read is in flight.
    applyStimulus(2'b01, {3'd0, 3'd6}, {8'h00, 8'h5A}, 2'b00, '0);
    @(negedge clk);
    checkOutput("wrPreReset", wrReady, 2'b01);
    nextCycle();
    reset = 1'b1;
    applyStimulus(2'b00, '0, '0, 2'b01, {3'd0, 3'd6});
    @(negedge clk);
    checkOutput("rdReadyPreReset", rdReady, 2'b01);
    nextCycle();
    reset = 1'b0;
    applyStimulus(2'b00, '0, '0, 2'b00, '0);
    @(negedge clk);
    checkOutput("resetSuppress", {rdDataValid, ramWrValid, ramWrAddr}, {2'b00, 1'b1, 3'd0});
    clearLen = 0;
    while (ramWrValid === 1'b1 && clearLen < 20) begin
      clearLen++;
      nextCycle();
      @(negedge clk);
    end
    checkOutput("reclearLen", clearLen, D);
    nextCycle();
    applyStimulus(2'b01, {3'd0, 3'd0}, {8'h00, 8'h99}, 2'b01, {3'd0, 3'd6});
    @(negedge clk);
    checkOutput("wrPostReset", wrReady, 2'b01);
    expectRead(2'b01, 8'h00);
    nextCycle();
    applyStimulus(2'b00, '0, '0, 2'b00, '0);
    nextCycle();

    // Idle: nothing moves, pointers hold at client 1.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle", {ramWrValid, ramRdValid, rdDataValid, wrReady, rdReady}, 0);
      nextCycle();
    end
    applyStimulus(2'b11, {3'd5, 3'd1}, {8'hCD, 8'hAB}, 2'b11, {3'd3, 3'd0});
    @(negedge clk);
    checkOutput("wrAfterIdle", {wrReady, ramWrAddr, ramWrData}, {2'b10, 3'd5, 8'hCD});
    expectRead(2'b10, 8'h00);
    nextCycle();
    applyStimulus(2'b00, '0, '0, 2'b11, {3'd3, 3'd0});
    @(negedge clk);
    expectRead(2'b01, 8'h99);
    nextCycle();
    applyStimulus(2'b00, '0, '0, 2'b10, {3'd5, 3'd0});
    @(negedge clk);
    expectRead(2'b10, 8'hCD);
    nextCycle();
    applyStimulus(2'b00, '0, '0, 2'b00, '0);
    @(negedge clk);
    #3;
    checkOutput("sbDrainedB", sbQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
